// File: rtl/shift_issue_ctrl_pkg.sv
// shift_issue_ctrl_pkg: shared shifter direction codes, FSM state encoding and default latency
package shift_issue_ctrl_pkg;
  localparam logic [1:0] DIR_PASS = 2'b00;
  localparam logic [1:0] DIR_SLL = 2'b01;
  localparam logic [1:0] DIR_SRL = 2'b10;
  localparam logic [1:0] DIR_SRA = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam int SHIFT_LAT_DEF = 5;
endpackage

// File: rtl/shift_issue_ctrl.sv
// shift_issue_ctrl: issues one op to the registered barrel shifter, waits out its latency, holds the result for writeback
module shift_issue_ctrl
  import shift_issue_ctrl_pkg::*;
#(
  parameter int SHIFT_LAT = SHIFT_LAT_DEF,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_src,
  input  logic [3:0]  req_shamt,
  input  logic [1:0]  req_dir,
  output logic [15:0] sh_src,
  output logic [3:0]  sh_shamt,
  output logic [1:0]  sh_dir,
  input  logic [15:0] sh_out,
  input  logic        sh_zr,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_zr,
  output logic        busy
);
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_sh_src;
  logic [3:0]       r_sh_shamt;
  logic [1:0]       r_sh_dir;
  logic [15:0]      r_res_data;
  logic             r_res_zr;
  logic             w_accept;
  // A new op may launch from IDLE, or from DONE in the same edge the held result retires; flush blocks both
  always_comb begin
    req_ready = ~flush & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & res_ready));
    w_accept = req_valid & req_ready;
  end
  // FSM, latency down-counter, operand launch registers and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_sh_src <= '0;
      r_sh_shamt <= '0;
      r_sh_dir <= DIR_PASS;
      r_res_data <= '0;
      r_res_zr <= 1'b0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_sh_dir <= DIR_PASS;
    end else if (w_accept) begin
      r_state <= ST_RUN;
      r_cnt <= CNT_W'(SHIFT_LAT);
      r_sh_src <= req_src;
      r_sh_shamt <= req_shamt;
      r_sh_dir <= req_dir;
    end else if (r_state == ST_RUN) begin
      if (r_cnt == '0) begin
        r_state <= ST_DONE;
        r_res_data <= sh_out;
        r_res_zr <= sh_zr;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if ((r_state == ST_DONE) & res_ready) begin
      r_state <= ST_IDLE;
    end
  end
  assign sh_src = r_sh_src;
  assign sh_shamt = r_sh_shamt;
  assign sh_dir = r_sh_dir;
  assign res_data = r_res_data;
  assign res_zr = r_res_zr;
  assign res_valid = r_state == ST_DONE;
  assign busy = r_state == ST_RUN;
endmodule

// File: tb/tb_shift_issue_ctrl.sv
// tb_shift_issue_ctrl: directed and randomized checks of the shift issue sequencer against a 5-stage shifter model
module tb_shift_issue_ctrl;
  localparam int LAT = 5;
  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, res_valid, res_ready, res_zr, busy, sh_zr;
  logic [15:0] req_src, sh_src, sh_out, res_data;
  logic [3:0]  req_shamt, sh_shamt;
  logic [1:0]  req_dir, sh_dir;
  logic [16:0] pipe [LAT];
  int          checks = 0;
  int          fails = 0;
  logic [15:0] exp_d;
  logic        in_done;

  shift_issue_ctrl #(.SHIFT_LAT(LAT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_shamt(req_shamt), .req_dir(req_dir),
    .sh_src(sh_src), .sh_shamt(sh_shamt), .sh_dir(sh_dir), .sh_out(sh_out), .sh_zr(sh_zr),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_zr(res_zr), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] shift_ref(input logic [15:0] s, input logic [3:0] a, input logic [1:0] d);
    logic signed [15:0] ss;
    ss = s;
    return d == 2'b00 ? s : d == 2'b01 ? s << a : d == 2'b10 ? s >> a : 16'(ss >>> a);
  endfunction

  always_ff @(posedge clk) begin
    pipe[0] <= {shift_ref(sh_src, sh_shamt, sh_dir) == 16'h0, shift_ref(sh_src, sh_shamt, sh_dir)};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sh_out = pipe[LAT-1][15:0];
  assign sh_zr = pipe[LAT-1][16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [15:0] s, input logic [3:0] a, input logic [1:0] d);
    req_src = s; req_shamt = a; req_dir = d; req_valid = 1'b1; res_ready = 1'b1;
    #1;
    chk("req_ready_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; res_ready = 1'b0;
    chk("busy_e0", busy, 1);
    chk("req_ready_e0", req_ready, 0);
    chk("res_valid_e0", res_valid, 0);
    chk("sh_src", sh_src, s);
    chk("sh_shamt", sh_shamt, a);
    chk("sh_dir", sh_dir, d);
    exp_d = shift_ref(s, a, d);
  endtask

  task automatic wait_result();
    for (int i = 1; i <= LAT; i++) begin
      @(posedge clk); #1;
      chk("busy_run", busy, 1);
      chk("res_valid_run", res_valid, 0);
      chk("req_ready_run", req_ready, 0);
    end
    @(posedge clk); #1;
    chk("res_valid_cap", res_valid, 1);
    chk("busy_cap", busy, 0);
    chk("res_data", res_data, exp_d);
    chk("res_zr", res_zr, exp_d == 16'h0);
    in_done = 1'b1;
  endtask

  task automatic stall(input int n);
    logic [15:0] s0;
    s0 = sh_src;
    req_valid = 1'b1; res_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("req_ready_stall", req_ready, 0);
      @(posedge clk); #1;
      chk("res_valid_hold", res_valid, 1);
      chk("res_data_hold", res_data, exp_d);
      chk("sh_src_hold", sh_src, s0);
    end
    req_valid = 1'b0;
  endtask

  task automatic retire();
    req_valid = 1'b0; res_ready = 1'b1;
    #1;
    chk("req_ready_retire", req_ready, 1);
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("res_valid_retire", res_valid, 0);
    chk("busy_retire", busy, 0);
    in_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_src = '0; req_shamt = '0; req_dir = '0; in_done = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_sh", {sh_src, sh_shamt, sh_dir}, 0);
    issue(16'h0001, 4'd4, 2'b01); wait_result(); retire();
    issue(16'h8000, 4'd15, 2'b11); wait_result(); retire();
    issue(16'h8000, 4'd15, 2'b10); wait_result(); retire();
    issue(16'h8000, 4'd1, 2'b01); wait_result(); retire();
    issue(16'h0000, 4'd3, 2'b00); wait_result(); retire();
    issue(16'h000F, 4'd4, 2'b01); wait_result(); stall(3); retire();
    issue(16'h00A5, 4'd2, 2'b01); wait_result();
    issue(16'hF000, 4'd12, 2'b10); wait_result(); retire();
    issue(16'h1234, 4'd8, 2'b01);
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1; req_valid = 1'b1; #1;
    chk("req_ready_flush", req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_res_valid", res_valid, 0);
    chk("flush_sh_dir", sh_dir, 0);
    issue(16'h00F0, 4'd4, 2'b10); wait_result(); retire();
    issue(16'hBEEF, 4'd3, 2'b11);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res", {res_data, res_zr}, 0);
    chk("midrst_sh", {sh_src, sh_shamt, sh_dir}, 0);
    chk("midrst_req_ready", req_ready, 1);
    in_done = 1'b0;
    for (int k = 0; k < 24; k++) begin
      logic [15:0] s;
      logic [3:0] a;
      logic [1:0] d;
      s = 16'($urandom); a = 4'($urandom); d = 2'($urandom);
      if (in_done && $urandom_range(0, 1) == 0) retire();
      issue(s, a, d);
      wait_result();
      if ($urandom_range(0, 2) == 0) stall($urandom_range(1, 3));
    end
    if (in_done) retire();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/shift_issue_ctrl.md
Name: shift_issue_ctrl

Overview:
Issue/retire sequencer for the execute-stage barrel shifter. Accepts one shift request per valid/ready handshake, drives the shifter's src/shamt/dir inputs and holds them stable for the shifter's full registered latency, then captures the shift result and zero flag. Presents result and flag to the writeback side on a valid/ready handshake. Sits between the ID/EX operand path (upstream) and the shifter instance; the shifter is instantiated beside this block, not inside it.

Parameters:
SHIFT_LAT, 5, clock edges after operand launch until both sh_out and sh_zr are valid (4 internal stages + zero-flag register)
CNT_W, 3, counter width; must satisfy 2^CNT_W > SHIFT_LAT

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous pipeline flush; abandons any in-flight op
req_valid  input  1  upstream request valid
req_ready  output  1  block can accept request this cycle
req_src  input  16  operand to shift
req_shamt  input  4  shift amount 0..15
req_dir  input  2  00 pass, 01 SLL, 10 SRL, 11 SRA
sh_src  output  16  to shifter src
sh_shamt  output  4  to shifter shamt
sh_dir  output  2  to shifter dir
sh_out  input  16  from shifter out
sh_zr  input  1  from shifter zr
res_valid  output  1  result valid
res_ready  input  1  downstream accepts result
res_data  output  16  captured shift result
res_zr  output  1  captured zero flag (1 iff res_data == 0)
busy  output  1  op in flight (state RUN)

Behaviour:
- Clock port is clk; reset port is rst, synchronous, active-high, sampled on rising clk.
- Reset: state IDLE, counter 0; sh_src/sh_shamt/sh_dir = 0; res_data 0, res_zr 0, res_valid 0, busy 0; req_ready 1 in the first cycle after reset.
- States: IDLE, RUN, DONE.
- req_ready (combinational) = (state==IDLE) | (state==DONE & res_ready), and 0 whenever flush=1.
- Accept = req_valid & req_ready. On the accept edge (E0), register req_src/shamt/dir into sh_src/sh_shamt/sh_dir, load counter = SHIFT_LAT, go RUN.
- RUN: sh_* held constant. Counter decrements once per edge. In the cycle where counter==0, the next edge captures sh_out -> res_data and sh_zr -> res_zr, sets res_valid, and goes DONE. Capture is at edge E0+SHIFT_LAT+1 (E6 at default). busy=1 throughout RUN only.
- DONE: res_valid=1; res_data/res_zr stable until handshake. On res_valid & res_ready: if req_valid, accept the new request in the same edge (RUN, back-to-back); otherwise go IDLE with res_valid=0.
- Minimum request-to-request period: SHIFT_LAT+2 cycles.
- sh_* hold the last launched operands after capture until the next accept. No shifter re-launch while in RUN.
- flush=1 on any edge: state IDLE, res_valid 0, counter 0, sh_dir 00. flush takes priority over a simultaneous accept or result handshake; the result is dropped.
- rst has priority over flush. rst asserted mid-RUN or in DONE returns all outputs to reset values on that edge.
- Results are captured unaltered from the shifter; no recompute of zr. Pass mode (dir 00) returns src.

Decomposition:
- Shared package: dir codes (DIR_PASS=00, DIR_SLL=01, DIR_SRL=10, DIR_SRA=11), state encoding (IDLE/RUN/DONE), default SHIFT_LAT=5.
- No sub-module; the FSM and down-counter stay in one module. The bench instantiates the shifter and connects the sh_* ports.

Test Plan:
- SLL src 0x0001 shamt 4, accepted at E0, res_ready=1 -> res_valid rises at E6 with res_data 0x0010, res_zr 0; busy high E0..E5; req_ready low E0..E6 until handshake.
- SRA src 0x8000 shamt 15 -> res_data 0xFFFF, res_zr 0; SRL same operands -> 0x0001; SLL src 0x8000 shamt 1 -> 0x0000, res_zr 1; pass src 0x0000 -> 0x0000, res_zr 1.
- Backpressure: result 0x00F0 ready, res_ready low 3 cycles -> res_valid and data held, req_ready 0, sh_* unchanged; on res_ready=1 with req_valid=0 -> IDLE.
- Back-to-back: in DONE, res_ready=1 and req_valid=1 (SRL 0xF000 shamt 12) -> same-edge accept; next res_data 0x000F six cycles later.
- Flush at E3 of an SLL 0x1234 shamt 8 -> state IDLE, res_valid never asserted, sh_dir 00; a request issued the next cycle completes normally.
- rst asserted mid-RUN with req_valid high -> all outputs return to reset values; req_ready=1 the cycle after rst deasserts.
